// File: rtl/apb_pkg.sv
// Shared types and defaults for the multi-subordinate APB3 manager.
package apb_pkg;

    // Manager FSM: request capture in IDLE, address phase in SETUP, data phase in ACCESS.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic [31:0] DEF_BASE_ADDR     = 32'h1000_0000;
    localparam int          DEF_SLV_SPAN_BITS = 12;
    localparam int          DEF_TIMEOUT_CYC   = 16;

    // Width of a subordinate index; a single subordinate still gets a 1-bit index.
    function automatic int idx_width(input int num_slv);
        return (num_slv > 1) ? $clog2(num_slv) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Regular address decoder: subordinate i owns the 2^SLV_SPAN_BITS window
// starting at BASE_ADDR + (i << SLV_SPAN_BITS). Purely combinational.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int                NUM_SLV       = 4,
    parameter int                ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = ADDR_W'(DEF_BASE_ADDR),
    parameter int                SLV_SPAN_BITS = DEF_SLV_SPAN_BITS,
    parameter int                IDX_W         = idx_width(NUM_SLV)
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic               hit,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_SLV-1:0] sel
);

    localparam logic [ADDR_W-1:0] NUM_SLV_A = ADDR_W'(NUM_SLV);

    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] window;

    // Comparing the window number rather than BASE_ADDR + size avoids an
    // overflowing upper bound when the mapped region ends at the top of memory.
    assign offset = addr - BASE_ADDR;
    assign window = offset >> SLV_SPAN_BITS;
    assign hit    = (addr >= BASE_ADDR) && (window < NUM_SLV_A);
    assign idx    = window[IDX_W-1:0];
    assign sel    = hit ? (NUM_SLV'(1) << idx) : '0;

endmodule

// File: rtl/apb_manager_nslv.sv
// APB3 manager bridging a simple request interface onto NUM_SLV subordinates.
// Supports PSLVERR propagation, unmapped-address error completion and
// back-to-back transfers. Define APB_MGR_TIMEOUT_EN to force-complete an
// ACCESS phase with an error after TIMEOUT_CYC unanswered cycles.
module apb_manager_nslv
    import apb_pkg::*;
#(
    parameter int                NUM_SLV       = 4,
    parameter int                ADDR_W        = 32,
    parameter int                DATA_W        = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = ADDR_W'(DEF_BASE_ADDR),
    parameter int                SLV_SPAN_BITS = DEF_SLV_SPAN_BITS,
    parameter int                TIMEOUT_CYC   = DEF_TIMEOUT_CYC
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    output logic [ADDR_W-1:0]         PADDR,
    output logic                      PWRITE,
    output logic                      PENABLE,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [NUM_SLV-1:0]        PSEL,
    input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLV-1:0]        PREADY,
    input  logic [NUM_SLV-1:0]        PSLVERR,
    input  logic                      transfer,
    input  logic                      write,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ready,
    output logic                      error
);

    localparam int IDX_W = idx_width(NUM_SLV);

    apb_state_e         state;
    apb_state_e         state_next;
    logic [ADDR_W-1:0]  addr_q;
    logic               write_q;
    logic [DATA_W-1:0]  wdata_q;

    logic               hit;
    logic [IDX_W-1:0]   idx;
    logic [NUM_SLV-1:0] sel;

    logic               sel_ready;
    logic               sel_err;
    logic [DATA_W-1:0]  sel_rdata;

    logic               in_access;
    logic               timeout_hit;
    logic               done;
    logic               accept;

    apb_addr_decode #(
        .NUM_SLV       (NUM_SLV),
        .ADDR_W        (ADDR_W),
        .BASE_ADDR     (BASE_ADDR),
        .SLV_SPAN_BITS (SLV_SPAN_BITS),
        .IDX_W         (IDX_W)
    ) u_decode (
        .addr (addr_q),
        .hit  (hit),
        .idx  (idx),
        .sel  (sel)
    );

    // Pick out the addressed subordinate's response; all others are ignored.
    always_comb begin
        sel_ready = PREADY[idx];
        sel_err   = PSLVERR[idx];
        sel_rdata = PRDATA[idx*DATA_W +: DATA_W];
    end

    assign in_access = (state == ACCESS);

`ifdef APB_MGR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;

    // Count unanswered ACCESS cycles; cleared on the SETUP -> ACCESS step.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wait_cnt <= '0;
        end else if (state == SETUP) begin
            wait_cnt <= '0;
        end else if (in_access && hit && !sel_ready) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign timeout_hit = in_access && hit && !sel_ready &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // An unmapped address finishes in its first ACCESS cycle with no bus activity.
    assign done   = in_access && (!hit || sel_ready || timeout_hit);
    assign accept = transfer && ((state == IDLE) || done);

    // Next-state logic; a request seen at completion goes straight back to SETUP.
    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (done) state_next = transfer ? SETUP : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any transfer in flight without a completion.
    always_ff @(posedge PCLK or posedge PRESET) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the request on acceptance; values hold across IDLE.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= addr;
            write_q <= write;
            wdata_q <= wdata;
        end
    end

    assign PADDR   = addr_q;
    assign PWRITE  = write_q;
    assign PWDATA  = wdata_q;
    assign PSEL    = ((state == SETUP) || in_access) ? sel : '0;
    assign PENABLE = in_access && hit;

    assign ready = done;
    assign error = done && (!hit || timeout_hit || sel_err);
    assign rdata = (in_access && hit && sel_ready && !write_q) ? sel_rdata : '0;

endmodule

// File: tb/tb_apb_manager_nslv.sv
// Self-checking bench for apb_manager_nslv: directed cycle checks plus
// randomized traffic scored against a behavioural model of the address map.
module tb_apb_manager_nslv;

    localparam int          NUM_SLV = 4;
    localparam int          DATA_W  = 32;
    localparam logic [31:0] BASE    = 32'h1000_0000;

    logic         PCLK, PRESET;
    logic [31:0]  PADDR;
    logic         PWRITE, PENABLE;
    logic [31:0]  PWDATA;
    logic [3:0]   PSEL;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY, PSLVERR;
    logic         transfer, write;
    logic [31:0]  addr, wdata, rdata;
    logic         ready, error;

    apb_manager_nslv #(
        .NUM_SLV(NUM_SLV), .ADDR_W(32), .DATA_W(DATA_W),
        .BASE_ADDR(BASE), .SLV_SPAN_BITS(12), .TIMEOUT_CYC(16)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE),
        .PENABLE(PENABLE), .PWDATA(PWDATA), .PSEL(PSEL), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .transfer(transfer), .write(write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .error(error)
    );

    typedef struct { logic err; logic [31:0] rdata; } exp_t;

    int    checks = 0;
    int    errors = 0;
    exp_t  exp_q[$];
    exp_t  mon_e;
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];
    int    force_wait = -1;
    bit    hang = 1'b0;
    int    wait_left = 0;

    int          r_lat;
    bit          r_paddr_ok;
    logic [3:0]  r_psel_or;
    logic        r_err;
    logic [31:0] r_rd;

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Bench-level environment rules: unwritten locations read as addr^A5A5_0000,
    // and the top 256 bytes of every 4 KB window answer with PSLVERR.
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic in_err_region(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return o[11:0] >= 12'hF00;
    endfunction

    function automatic logic [3:0] ref_sel(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        if (off < 0 || off >= longint'(NUM_SLV) * 4096) return 4'b0000;
        return 4'b0001 << (off / 4096);
    endfunction

    // Reference model: expected completion for a request, updating the model memory.
    function automatic exp_t model(input bit w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        if (ref_sel(a) == 4'b0000) begin
            e.err = 1'b1;
            e.rdata = 32'h0;
            return e;
        end
        e.err = in_err_region(a);
        if (w) begin
            e.rdata = 32'h0;
            if (!e.err) ref_mem[a] = d;
        end else begin
            e.rdata = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        end
        return e;
    endfunction

    // Subordinate models: random noise on unselected lanes, memory behind the selected one.
    initial begin
        logic [3:0]   pr, pe;
        logic [127:0] prd;
        int           j;
        PREADY = '0; PSLVERR = '0; PRDATA = '0;
        forever begin
            @(posedge PCLK);
            #2;
            for (int k = 0; k < NUM_SLV; k++) prd[k*32 +: 32] = $urandom;
            pr = 4'($urandom);
            pe = 4'($urandom);
            j = -1;
            for (int k = 0; k < NUM_SLV; k++) if (PSEL[k]) j = k;
            if (j >= 0) begin
                if (!PENABLE) begin
                    wait_left = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
                end else if (!hang && wait_left == 0) begin
                    pr[j] = 1'b1;
                    pe[j] = in_err_region(PADDR);
                    if (PWRITE) begin
                        if (!pe[j]) slv_mem[PADDR] = PWDATA;
                    end else begin
                        prd[j*32 +: 32] = slv_mem.exists(PADDR) ? slv_mem[PADDR] : dflt(PADDR);
                    end
                end else begin
                    pr[j] = 1'b0;
                    if (wait_left > 0) wait_left--;
                end
            end
            PREADY = pr; PSLVERR = pe; PRDATA = prd;
        end
    end

    // Monitor: score every completion and check PSEL against the address map.
    always @(negedge PCLK) begin
        if (!PRESET && ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_ready actual=ready required=none");
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_error", error, mon_e.err);
                check("sb_rdata", rdata, mon_e.rdata);
            end
        end
        if (!PRESET && PSEL != 4'b0000) check("psel_decode", PSEL, ref_sel(PADDR));
    end

    // Issue one request from IDLE and follow it to completion (or budget expiry).
    task automatic run_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input bit noise, input int budget);
        r_lat = -1; r_paddr_ok = 1'b1; r_psel_or = '0; r_err = 1'b0; r_rd = '0;
        @(posedge PCLK);
        #1;
        transfer = 1'b1; write = w; addr = a; wdata = d;
        for (int n = 1; n <= budget; n++) begin
            @(negedge PCLK);
            if (n >= 2) begin
                if (PADDR !== a) r_paddr_ok = 1'b0;
                r_psel_or |= PSEL;
            end
            if (n == 2) begin
                if (noise) begin
                    write = ~w; addr = 32'h2000_0000; wdata = $urandom;
                end else begin
                    transfer = 1'b0;
                end
            end
            if (n == 3) transfer = 1'b0;
            if (ready) begin
                r_lat = n - 1; r_err = error; r_rd = rdata;
                break;
            end
        end
        transfer = 1'b0;
    endtask

    task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d, input bit noise);
        exp_q.push_back(model(w, a, d));
        run_req(w, a, d, noise, 60);
        check("req_complete", r_lat >= 0, 1);
    endtask

    task automatic start_hung(input logic [31:0] a);
        @(posedge PCLK);
        #1;
        transfer = 1'b1; write = 1'b0; addr = a;
        @(negedge PCLK);
        @(negedge PCLK);
        transfer = 1'b0;
    endtask

    initial begin
        bit          seen;
        bit          w;
        logic [31:0] a;
        exp_t        t;

        PRESET = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        #3;
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwrite", PWRITE, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_ready", ready, 0);
        check("rst_error", error, 0);
        check("rst_rdata", rdata, 0);
        #19 PRESET = 1'b0;

        // Zero-wait write, cycle by cycle
        force_wait = 0;
        exp_q.push_back(model(1'b1, 32'h1000_1004, 32'hDEAD_BEEF));
        @(posedge PCLK);
        #1;
        transfer = 1'b1; write = 1'b1; addr = 32'h1000_1004; wdata = 32'hDEAD_BEEF;
        @(negedge PCLK);
        @(negedge PCLK);
        transfer = 1'b0;
        check("zw_setup_psel", PSEL, 4'b0010);
        check("zw_setup_penable", PENABLE, 0);
        @(negedge PCLK);
        check("zw_access_penable", PENABLE, 1);
        check("zw_access_ready", ready, 1);
        check("zw_access_error", error, 0);
        check("zw_access_pwdata", PWDATA, 32'hDEAD_BEEF);
        @(negedge PCLK);
        check("zw_idle_psel", PSEL, 0);
        check("zw_idle_ready", ready, 0);

        // Wait-state read with request noise during SETUP
        do_req(1'b1, 32'h1000_3010, 32'h0000_00A5, 1'b0);
        force_wait = 3;
        do_req(1'b0, 32'h1000_3010, 32'h0, 1'b1);
        check("ws_latency", r_lat, 5);
        check("ws_paddr_stable", r_paddr_ok, 1);
        check("ws_rdata", r_rd, 32'h0000_00A5);

        // Back-to-back: second request raised in the completion cycle
        force_wait = 0;
        exp_q.push_back(model(1'b0, 32'h1000_2020, 32'h0));
        @(posedge PCLK);
        #1;
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_2020;
        @(negedge PCLK);
        @(negedge PCLK);
        transfer = 1'b0;
        @(negedge PCLK);
        check("b2b_first_ready", ready, 1);
        exp_q.push_back(model(1'b1, 32'h1000_0000, 32'h1234_5678));
        transfer = 1'b1; write = 1'b1; addr = 32'h1000_0000; wdata = 32'h1234_5678;
        @(negedge PCLK);
        transfer = 1'b0;
        check("b2b_setup_psel", PSEL, 4'b0001);
        check("b2b_setup_penable", PENABLE, 0);
        @(negedge PCLK);
        check("b2b_second_ready", ready, 1);
        do_req(1'b0, 32'h1000_0000, 32'h0, 1'b0);
        check("b2b_readback", r_rd, 32'h1234_5678);

        // Error responses and map boundaries
        force_wait = -1;
        do_req(1'b0, 32'h2000_0000, 32'h0, 1'b0);
        check("unmapped_latency", r_lat, 2);
        check("unmapped_error", r_err, 1);
        check("unmapped_psel", r_psel_or, 0);
        check("unmapped_rdata", r_rd, 0);
        do_req(1'b0, 32'h1000_1F04, 32'h0, 1'b0);
        check("pslverr_error", r_err, 1);
        check("pslverr_psel", r_psel_or, 4'b0010);
        do_req(1'b1, 32'h0FFF_FFFC, 32'h1111_1111, 1'b0);
        check("below_base_error", r_err, 1);
        do_req(1'b0, 32'h1000_4000, 32'h0, 1'b0);
        check("above_top_error", r_err, 1);
        check("above_top_psel", r_psel_or, 0);
        do_req(1'b0, 32'h1000_3FFC, 32'h0, 1'b0);
        check("top_word_psel", r_psel_or, 4'b1000);
        do_req(1'b0, 32'h1000_0000, 32'h0, 1'b0);
        check("base_word_psel", r_psel_or, 4'b0001);

        // Randomized traffic
        repeat (60) begin
            w = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 3))
                    0:       a = BASE - 32'd4;
                    1:       a = BASE + 32'h4000;
                    2:       a = 32'h0;
                    default: a = $urandom | 32'h8000_0000;
                endcase
            end else begin
                a = BASE + ($urandom_range(0, 3) << 12) + ($urandom_range(0, 3) << 2) +
                    (($urandom_range(0, 4) == 0) ? 32'hF00 : 32'h0);
            end
            do_req(w, a, $urandom, $urandom_range(0, 3) == 0);
            check("rand_latency", (r_lat >= 2) && (r_lat <= 5), 1);
        end

        // Unanswered ACCESS
`ifdef APB_MGR_TIMEOUT_EN
        hang = 1'b1;
        t.err = 1'b1; t.rdata = 32'h0;
        exp_q.push_back(t);
        run_req(1'b0, 32'h1000_0040, 32'h0, 1'b0, 40);
        check("tmo_latency", r_lat, 17);
        check("tmo_error", r_err, 1);
        check("tmo_rdata", r_rd, 0);
        @(negedge PCLK);
        check("tmo_psel_drop", PSEL, 0);
        start_hung(32'h1000_2008);
        repeat (3) @(negedge PCLK);
`else
        hang = 1'b1;
        start_hung(32'h1000_0040);
        seen = 1'b0;
        repeat (100) begin
            @(negedge PCLK);
            if (ready) seen = 1'b1;
        end
        check("nto_no_ready", seen, 0);
        check("nto_psel", PSEL, 4'b0001);
`endif

        // Reset in the middle of ACCESS
        check("rst_mid_penable_before", PENABLE, 1);
        #2 PRESET = 1'b1;
        #1;
        check("rst_mid_psel", PSEL, 0);
        check("rst_mid_penable", PENABLE, 0);
        check("rst_mid_paddr", PADDR, 0);
        check("rst_mid_ready", ready, 0);
        hang = 1'b0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_hold_ready", ready, 0);
        #2 PRESET = 1'b0;
        force_wait = 1;
        do_req(1'b1, 32'h1000_2008, 32'hCAFE_F00D, 1'b0);
        check("post_rst_latency", r_lat, 3);
        check("post_rst_error", r_err, 0);
        do_req(1'b0, 32'h1000_2008, 32'h0, 1'b0);
        check("post_rst_rdata", r_rd, 32'hCAFE_F00D);

        repeat (3) @(negedge PCLK);
        check("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
